// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests, buffers words for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jmp_occur,
   input  logic [31:0] pc_jmpto,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = CW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [29:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
   logic [AW-1:0] fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
   logic [31:0]   pc_hold_q, pc_hold_d;
   logic [31:0]   aq_mem_q  [DEPTH];
   logic [31:0]   fq_pc_q   [DEPTH];
   logic [31:0]   fq_data_q [DEPTH];

   logic        hs, rsp_keep, push, pop, bypass;
   logic [31:0] rsp_pc;
   logic        unused_jmp_lsb;

   assign unused_jmp_lsb = ^pc_jmpto[1:0];

   // Issue, response accounting, FIFO control and output selection.
   always_comb begin
      rsp_pc         = aq_mem_q[aq_rd_q];
      imem_req_addr  = {fetch_pc_q, 2'b00};
      imem_req_valid = !rst && !jmp_occur &&
                       ((SW'(inflight_q) + SW'(count_q)) < SW'(DEPTH));
      hs             = imem_req_valid && imem_req_ready;
      rsp_keep       = imem_rsp_valid && (discard_q == '0) && !jmp_occur;
      bypass         = 1'b0;
`ifdef FETCH_BYPASS_EN
      bypass         = !rst && rsp_keep && (count_q == '0) && !stall;
`endif
      push           = rsp_keep && !bypass;
      pop            = (count_q != '0) && !stall && !jmp_occur;

      instr_valid = (count_q != '0) || bypass;
      instr_out   = NOP;
      pc_out      = pc_hold_q;
      if (count_q != '0) begin
         instr_out = fq_data_q[fq_rd_q];
         pc_out    = fq_pc_q[fq_rd_q];
      end else if (bypass) begin
         instr_out = imem_rsp_data;
         pc_out    = rsp_pc;
      end
      pc_hold_d = pc_out;

      inflight_d = inflight_q + CW'(hs) - CW'(imem_rsp_valid);
      aq_wr_d    = hs ? aq_wr_q + AW'(1) : aq_wr_q;
      aq_rd_d    = imem_rsp_valid ? aq_rd_q + AW'(1) : aq_rd_q;
      fetch_pc_d = hs ? fetch_pc_q + 30'(1) : fetch_pc_q;
      discard_d  = discard_q;
      if (imem_rsp_valid && (discard_q != '0))
         discard_d = discard_q - CW'(1);
      fq_wr_d = push ? fq_wr_q + AW'(1) : fq_wr_q;
      fq_rd_d = pop ? fq_rd_q + AW'(1) : fq_rd_q;
      count_d = count_q + CW'(push) - CW'(pop);

      // Redirect wins: flush buffered words and discard whatever is still in flight.
      if (jmp_occur) begin
         fetch_pc_d = pc_jmpto[31:2];
         discard_d  = inflight_d;
         fq_wr_d    = '0;
         fq_rd_d    = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC[31:2];
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         aq_wr_q    <= '0;
         aq_rd_q    <= '0;
         fq_wr_q    <= '0;
         fq_rd_q    <= '0;
         pc_hold_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         aq_wr_q    <= aq_wr_d;
         aq_rd_q    <= aq_rd_d;
         fq_wr_q    <= fq_wr_d;
         fq_rd_q    <= fq_rd_d;
         pc_hold_q  <= pc_hold_d;
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (hs)
         aq_mem_q[aq_wr_q] <= imem_req_addr;
      if (push) begin
         fq_pc_q[fq_wr_q]   <= rsp_pc;
         fq_data_q[fq_wr_q] <= imem_rsp_data;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (count_q == CW'(DEPTH))));
         assert (discard_q <= inflight_q);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (default build): directed cycle table, async reset sequence,
// and a randomized run against a queue-based reference model with a latency-varying memory.
module tb_fetch_unit;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          NROWS    = 20;
   localparam int          NRAND    = 3000;

   logic        clk = 1'b0;
   logic        rst, stall, jmp_occur, imem_req_ready, imem_rsp_valid;
   logic [31:0] pc_jmpto, imem_rsp_data;
   logic        imem_req_valid, instr_valid;
   logic [31:0] imem_req_addr, instr_out, pc_out;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .jmp_occur(jmp_occur), .pc_jmpto(pc_jmpto),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        stall, jmp, rsp;
      logic [31:0] jmpto, rsp_addr;
      logic        e_req, e_iv;
      logic [31:0] e_addr, e_instr, e_pc;
   } row_t;

   row_t tbl [NROWS];

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
   endfunction

   function automatic row_t mk(input logic s, input logic j, input logic [31:0] jt,
                               input logic rv, input logic [31:0] ra,
                               input logic er, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep);
      row_t r;
      r.stall = s; r.jmp = j; r.jmpto = jt; r.rsp = rv; r.rsp_addr = ra;
      r.e_req = er; r.e_addr = ea; r.e_iv = ev; r.e_pc = ep;
      r.e_instr = ev ? mdata(ep) : NOP;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic j, input logic [31:0] jt,
                        input logic rdy, input logic rv, input logic [31:0] rd);
      stall = s; jmp_occur = j; pc_jmpto = jt;
      imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr_out", instr_out, NOP);
      chk("rst_pc_out", pc_out, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model state: queues of in-flight addresses and buffered {pc, word}.
   logic [31:0] m_fpc, m_hold;
   int          m_discard;
   logic [31:0] m_inf[$];
   logic [31:0] m_bpc[$];
   logic [31:0] m_bdat[$];
   logic [31:0] mem_addr[$];
   int          mem_due[$];
   int          cyc, last_due;

   task automatic model_reset();
      m_fpc = RESET_PC; m_hold = 32'h0; m_discard = 0;
      m_inf.delete(); m_bpc.delete(); m_bdat.delete();
      mem_addr.delete(); mem_due.delete();
      cyc = 0; last_due = -1;
   endtask

   task automatic rand_cycle();
      logic s, j, rdy, rv, e_req, e_iv, hs;
      logic [31:0] jt, rd, ra, e_addr, e_instr, e_pc, a;
      int due;
      @(negedge clk);
      s   = ($urandom_range(0, 3) == 0);
      j   = ($urandom_range(0, 11) == 0);
      jt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : ($urandom & 32'h0000_FFFF);
      rdy = ($urandom_range(0, 3) != 0);
      rv = 1'b0; rd = 32'h0; ra = 32'h0;
      if (mem_addr.size() != 0 && mem_due[0] <= cyc) begin
         rv = 1'b1;
         ra = mem_addr.pop_front();
         void'(mem_due.pop_front());
         rd = mdata(ra);
      end
      e_req   = !j && ((m_inf.size() + m_bpc.size()) < DEPTH);
      e_addr  = m_fpc;
      e_iv    = (m_bpc.size() != 0);
      e_instr = e_iv ? m_bdat[0] : NOP;
      e_pc    = e_iv ? m_bpc[0] : m_hold;
      drive(s, j, jt, rdy, rv, rd);
      #1;
      chk("rnd_req_valid", imem_req_valid, e_req);
      if (e_req) chk("rnd_req_addr", imem_req_addr, e_addr);
      chk("rnd_instr_valid", instr_valid, e_iv);
      chk("rnd_instr_out", instr_out, e_instr);
      chk("rnd_pc_out", pc_out, e_pc);

      hs = e_req && rdy;
      m_hold = e_pc;
      if (!j && e_iv && !s) begin
         void'(m_bpc.pop_front());
         void'(m_bdat.pop_front());
      end
      if (rv && m_inf.size() != 0) begin
         a = m_inf.pop_front();
         if (m_discard > 0) m_discard--;
         else if (!j) begin
            m_bpc.push_back(a);
            m_bdat.push_back(rd);
         end
      end
      if (j) begin
         m_bpc.delete(); m_bdat.delete();
         m_fpc = {jt[31:2], 2'b00};
         m_discard = m_inf.size();
      end else if (hs) begin
         m_inf.push_back(m_fpc);
         due = cyc + $urandom_range(1, 3);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_addr.push_back(m_fpc);
         mem_due.push_back(due);
         m_fpc = m_fpc + 32'd4;
      end
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Columns: stall, jmp, jmpto, rsp, rsp_addr | req_valid, req_addr, instr_valid, pc_out
      tbl[0]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'h0);
      tbl[1]  = mk(0, 0, 32'h0,         1, 32'h0,         1, 32'h4,         0, 32'h0);
      tbl[2]  = mk(1, 0, 32'h0,         1, 32'h4,         0, 32'h8,         1, 32'h0);
      tbl[3]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h0);
      tbl[4]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h0);
      tbl[5]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h0);
      tbl[6]  = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h0);
      tbl[7]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         1, 32'h0);
      tbl[8]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 32'h4);
      tbl[9]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hC,         0, 32'h4);
      tbl[10] = mk(0, 1, 32'h100,       1, 32'h8,         0, 32'h10,        0, 32'h4);
      tbl[11] = mk(0, 0, 32'h0,         1, 32'hC,         1, 32'h100,       0, 32'h4);
      tbl[12] = mk(0, 0, 32'h0,         1, 32'h100,       1, 32'h104,       0, 32'h4);
      tbl[13] = mk(1, 1, 32'h203,       1, 32'h104,       0, 32'h108,       1, 32'h100);
      tbl[14] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h200,       0, 32'h100);
      tbl[15] = mk(0, 1, 32'hFFFF_FFFC, 1, 32'h200,       0, 32'h204,       0, 32'h100);
      tbl[16] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h100);
      tbl[17] = mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0,         0, 32'h100);
      tbl[18] = mk(0, 0, 32'h0,         1, 32'h0,         0, 32'h4,         1, 32'hFFFF_FFFC);
      tbl[19] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         1, 32'h0);

      do_reset();
      for (int i = 0; i < NROWS; i++) begin
         @(negedge clk);
         drive(tbl[i].stall, tbl[i].jmp, tbl[i].jmpto, 1'b1, tbl[i].rsp,
               tbl[i].rsp ? mdata(tbl[i].rsp_addr) : 32'h0);
         #1;
         chk($sformatf("row%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
         chk($sformatf("row%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
         chk($sformatf("row%0d_instr_valid", i), instr_valid, tbl[i].e_iv);
         chk($sformatf("row%0d_instr_out", i), instr_out, tbl[i].e_instr);
         chk($sformatf("row%0d_pc_out", i), pc_out, tbl[i].e_pc);
      end

      // Fill the FIFO under stall, then assert reset asynchronously mid-cycle.
      do_reset();
      @(negedge clk); drive(1, 0, 32'h0, 1, 0, 32'h0);
      @(negedge clk); drive(1, 0, 32'h0, 1, 1, mdata(32'h0));
      @(negedge clk); drive(1, 0, 32'h0, 1, 1, mdata(32'h4));
      @(negedge clk); drive(1, 0, 32'h0, 1, 0, 32'h0);
      #1;
      chk("full_instr_valid", instr_valid, 1'b1);
      chk("full_pc_out", pc_out, 32'h0);
      chk("full_req_valid", imem_req_valid, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_instr_valid", instr_valid, 1'b0);
      chk("async_instr_out", instr_out, NOP);
      chk("async_pc_out", pc_out, 32'h0);
      chk("async_req_valid", imem_req_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      #1;
      chk("post_rst_req_valid", imem_req_valid, 1'b1);
      chk("post_rst_req_addr", imem_req_addr, RESET_PC);
      chk("post_rst_instr_valid", instr_valid, 1'b0);

      model_reset();
      for (int n = 0; n < NRAND; n++) rand_cycle();

      @(negedge clk);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
